// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// downstream hold and branch flush; also drives the PC and IF/ID write enables.
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned LOAD_USE_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [3:0]            id_registerA,
    input  logic [3:0]            id_registerB,
    input  logic [3:0]            id_registerRD,
    input  logic                  id_regWrite,
    input  logic                  id_memRead,
    input  logic                  id_memWrite,
    input  logic                  id_ALUSrc,
    input  logic                  id_dataBRegisterFileSelector,
    input  logic [3:0]            id_aluOp,
    input  logic [DATA_WIDTH-1:0] id_dataA,
    input  logic [DATA_WIDTH-1:0] id_dataB,
    input  logic [DATA_WIDTH-1:0] id_immediate,
    input  logic                  flush,
    input  logic                  ex_stall,
    output logic                  id_ex_valid,
    output logic                  id_ex_regWrite,
    output logic                  id_ex_memRead,
    output logic                  id_ex_memWrite,
    output logic                  id_ex_ALUSrc,
    output logic                  id_ex_dataBRegisterFileSelector,
    output logic [3:0]            id_ex_registerA,
    output logic [3:0]            id_ex_registerB,
    output logic [3:0]            id_ex_registerRD,
    output logic [3:0]            id_ex_aluOp,
    output logic [DATA_WIDTH-1:0] id_ex_dataA,
    output logic [DATA_WIDTH-1:0] id_ex_dataB,
    output logic [DATA_WIDTH-1:0] id_ex_immediate,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  if_id_write
);

    localparam logic [2:0] RELOAD = 3'(LOAD_USE_CYCLES - 1);

    logic [2:0] hazard_cnt;
    logic [2:0] hazard_cnt_next;
    logic       uses_b;
    logic       hazard_now;
    logic       bubble;
    logic       load;

    always_comb begin
        uses_b     = id_dataBRegisterFileSelector | ~id_ALUSrc;
        hazard_now = id_valid & id_ex_valid & id_ex_memRead & id_ex_regWrite &
                     ((id_ex_registerRD == id_registerA) |
                      (uses_b & (id_ex_registerRD == id_registerB)));
        stall      = ~flush & (ex_stall | hazard_now | (hazard_cnt != '0));
    end

    assign pc_write    = ~stall;
    assign if_id_write = ~stall;

    // Flush outranks hold, hold outranks hazard bubbles; the counter only
    // reloads when a fresh hazard is seen with no bubbles outstanding.
    always_comb begin
        bubble          = 1'b0;
        load            = 1'b0;
        hazard_cnt_next = hazard_cnt;
        if (flush) begin
            bubble          = 1'b1;
            hazard_cnt_next = '0;
        end else if (!ex_stall) begin
            if (hazard_cnt != '0) begin
                bubble          = 1'b1;
                hazard_cnt_next = hazard_cnt - 3'd1;
            end else if (hazard_now) begin
                bubble          = 1'b1;
                hazard_cnt_next = RELOAD;
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hazard_cnt <= '0;
        end else begin
            hazard_cnt <= hazard_cnt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || bubble) begin
            id_ex_valid                     <= 1'b0;
            id_ex_regWrite                  <= 1'b0;
            id_ex_memRead                   <= 1'b0;
            id_ex_memWrite                  <= 1'b0;
            id_ex_ALUSrc                    <= 1'b0;
            id_ex_dataBRegisterFileSelector <= 1'b0;
            id_ex_registerA                 <= '0;
            id_ex_registerB                 <= '0;
            id_ex_registerRD                <= '0;
            id_ex_aluOp                     <= '0;
            id_ex_dataA                     <= '0;
            id_ex_dataB                     <= '0;
            id_ex_immediate                 <= '0;
        end else if (load) begin
            // Side-effecting controls are squashed for non-instructions so the
            // forwarding unit never sees a phantom write.
            id_ex_valid                     <= id_valid;
            id_ex_regWrite                  <= id_regWrite & id_valid;
            id_ex_memRead                   <= id_memRead & id_valid;
            id_ex_memWrite                  <= id_memWrite & id_valid;
            id_ex_ALUSrc                    <= id_ALUSrc;
            id_ex_dataBRegisterFileSelector <= id_dataBRegisterFileSelector;
            id_ex_registerA                 <= id_registerA;
            id_ex_registerB                 <= id_registerB;
            id_ex_registerRD                <= id_registerRD;
            id_ex_aluOp                     <= id_aluOp;
            id_ex_dataA                     <= id_dataA;
            id_ex_dataB                     <= id_dataB;
            id_ex_immediate                 <= id_immediate;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (1 and 3 load-use bubbles) driven in
// lockstep, directed vectors plus random traffic against a behavioural model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        reset, valid, flush, ex_stall;
        logic [3:0]  ra, rb, rd;
        logic        rw, mr, mw, alusrc, sel;
        logic [3:0]  aluop;
        logic [31:0] da, db, imm;
    } in_t;

    typedef struct packed {
        logic        valid, rw, mr, mw, alusrc, sel;
        logic [3:0]  ra, rb, rd, aluop;
        logic [31:0] da, db, imm;
    } stage_t;

    typedef struct {
        in_t         stim;
        logic        exp_stall;
        logic        exp_valid;
        logic        exp_rw;
        logic [3:0]  exp_rd;
        logic [31:0] exp_da;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    in_t cur;
    int  nvec = 0;
    int  nerr = 0;

    logic        a_valid, a_rw, a_mr, a_mw, a_alusrc, a_sel, a_stall, a_pc, a_ifid;
    logic [3:0]  a_ra, a_rb, a_rd, a_aluop;
    logic [31:0] a_da, a_db, a_imm;
    logic        b_valid, b_rw, b_mr, b_mw, b_alusrc, b_sel, b_stall, b_pc, b_ifid;
    logic [3:0]  b_ra, b_rb, b_rd, b_aluop;
    logic [31:0] b_da, b_db, b_imm;

    id_ex_stage #(.DATA_WIDTH(32), .LOAD_USE_CYCLES(1)) dut1 (
        .clock(clock), .reset(cur.reset), .id_valid(cur.valid),
        .id_registerA(cur.ra), .id_registerB(cur.rb), .id_registerRD(cur.rd),
        .id_regWrite(cur.rw), .id_memRead(cur.mr), .id_memWrite(cur.mw),
        .id_ALUSrc(cur.alusrc), .id_dataBRegisterFileSelector(cur.sel),
        .id_aluOp(cur.aluop), .id_dataA(cur.da), .id_dataB(cur.db),
        .id_immediate(cur.imm), .flush(cur.flush), .ex_stall(cur.ex_stall),
        .id_ex_valid(a_valid), .id_ex_regWrite(a_rw), .id_ex_memRead(a_mr),
        .id_ex_memWrite(a_mw), .id_ex_ALUSrc(a_alusrc),
        .id_ex_dataBRegisterFileSelector(a_sel), .id_ex_registerA(a_ra),
        .id_ex_registerB(a_rb), .id_ex_registerRD(a_rd), .id_ex_aluOp(a_aluop),
        .id_ex_dataA(a_da), .id_ex_dataB(a_db), .id_ex_immediate(a_imm),
        .stall(a_stall), .pc_write(a_pc), .if_id_write(a_ifid)
    );

    id_ex_stage #(.DATA_WIDTH(32), .LOAD_USE_CYCLES(3)) dut3 (
        .clock(clock), .reset(cur.reset), .id_valid(cur.valid),
        .id_registerA(cur.ra), .id_registerB(cur.rb), .id_registerRD(cur.rd),
        .id_regWrite(cur.rw), .id_memRead(cur.mr), .id_memWrite(cur.mw),
        .id_ALUSrc(cur.alusrc), .id_dataBRegisterFileSelector(cur.sel),
        .id_aluOp(cur.aluop), .id_dataA(cur.da), .id_dataB(cur.db),
        .id_immediate(cur.imm), .flush(cur.flush), .ex_stall(cur.ex_stall),
        .id_ex_valid(b_valid), .id_ex_regWrite(b_rw), .id_ex_memRead(b_mr),
        .id_ex_memWrite(b_mw), .id_ex_ALUSrc(b_alusrc),
        .id_ex_dataBRegisterFileSelector(b_sel), .id_ex_registerA(b_ra),
        .id_ex_registerB(b_rb), .id_ex_registerRD(b_rd), .id_ex_aluOp(b_aluop),
        .id_ex_dataA(b_da), .id_ex_dataB(b_db), .id_ex_immediate(b_imm),
        .stall(b_stall), .pc_write(b_pc), .if_id_write(b_ifid)
    );

    stage_t q [2];
    logic   q_stall [2];
    logic   q_pc [2];
    logic   q_ifid [2];

    always_comb begin
        q[0] = {a_valid, a_rw, a_mr, a_mw, a_alusrc, a_sel, a_ra, a_rb, a_rd, a_aluop, a_da, a_db, a_imm};
        q[1] = {b_valid, b_rw, b_mr, b_mw, b_alusrc, b_sel, b_ra, b_rb, b_rd, b_aluop, b_da, b_db, b_imm};
        q_stall[0] = a_stall; q_stall[1] = b_stall;
        q_pc[0]    = a_pc;    q_pc[1]    = b_pc;
        q_ifid[0]  = a_ifid;  q_ifid[1]  = b_ifid;
    end

    // Reference: what EX currently holds and how many extra bubbles are owed.
    stage_t      m [2];
    int unsigned owed [2];
    int unsigned bubbles [2] = '{1, 3};
    logic        s_stall [2];
    logic        s_pc [2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic depends_on_load(int k);
        logic reads_b;
        reads_b = cur.sel || !cur.alusrc;
        return cur.valid && m[k].valid && m[k].mr && m[k].rw &&
               (m[k].rd == cur.ra || (reads_b && m[k].rd == cur.rb));
    endfunction

    function automatic logic model_stall(int k);
        if (cur.flush) return 1'b0;
        return cur.ex_stall || depends_on_load(k) || owed[k] > 0;
    endfunction

    task automatic cycle(input in_t s);
        stage_t      nm [2];
        int unsigned nowed [2];
        cur = s;
        #3;
        for (int k = 0; k < 2; k++) begin
            s_stall[k] = q_stall[k];
            s_pc[k]    = q_pc[k];
            chk($sformatf("stall[%0d]", k), q_stall[k], model_stall(k));
            chk($sformatf("pc_write[%0d]", k), q_pc[k], !model_stall(k));
            chk($sformatf("if_id_write[%0d]", k), q_ifid[k], !model_stall(k));
            nm[k] = m[k];
            nowed[k] = owed[k];
            if (!cur.reset || cur.flush) begin
                nm[k] = '0;
                nowed[k] = 0;
            end else if (cur.ex_stall) begin
                // nothing moves
            end else if (owed[k] > 0) begin
                nm[k] = '0;
                nowed[k] = owed[k] - 1;
            end else if (depends_on_load(k)) begin
                nm[k] = '0;
                nowed[k] = bubbles[k] - 1;
            end else begin
                nm[k] = {cur.valid, cur.rw && cur.valid, cur.mr && cur.valid,
                         cur.mw && cur.valid, cur.alusrc, cur.sel, cur.ra, cur.rb,
                         cur.rd, cur.aluop, cur.da, cur.db, cur.imm};
            end
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            m[k] = nm[k];
            owed[k] = nowed[k];
            chk($sformatf("id_ex[%0d]", k), q[k], m[k]);
        end
    endtask

    function automatic in_t mk(logic v, logic [3:0] ra, logic [3:0] rb, logic [3:0] rd,
                               logic rw, logic mr, logic alusrc, logic sel);
        in_t r;
        r = '0;
        r.reset = 1'b1;
        r.valid = v; r.ra = ra; r.rb = rb; r.rd = rd;
        r.rw = rw; r.mr = mr; r.alusrc = alusrc; r.sel = sel;
        r.db = 32'h5A5A_0000 + 32'(rd);
        r.imm = 32'h0000_0100 + 32'(ra);
        return r;
    endfunction

    function automatic in_t rnd();
        in_t r;
        r.reset    = $urandom_range(0, 49) != 0;
        r.flush    = $urandom_range(0, 9) == 0;
        r.ex_stall = $urandom_range(0, 7) == 0;
        r.valid    = $urandom_range(0, 5) != 0;
        r.ra = 4'($urandom_range(0, 3)); r.rb = 4'($urandom_range(0, 3));
        r.rd = 4'($urandom_range(0, 3));
        r.rw = 1'($urandom); r.mr = 1'($urandom); r.mw = 1'($urandom);
        r.alusrc = 1'($urandom); r.sel = 1'($urandom);
        r.aluop = 4'($urandom);
        r.da = $urandom; r.db = $urandom; r.imm = $urandom;
        return r;
    endfunction

    vec_t tbl [7];
    in_t  dep;

    initial begin
        m = '{default: '0};
        owed = '{0, 0};
        tbl[0].stim = '1; tbl[0].stim.reset = 1'b0;
        tbl[1] = tbl[0];
        tbl[2].stim = mk(1, 0, 0, 5, 1, 0, 1, 0);
        tbl[2].stim.da = 32'h1234; tbl[2].stim.aluop = 4'd3;
        tbl[3].stim = mk(1, 1, 2, 3, 1, 1, 1, 0);
        tbl[4].stim = mk(1, 3, 0, 4, 1, 0, 1, 0);
        tbl[5].stim = tbl[4].stim;
        tbl[6].stim = mk(0, 0, 0, 9, 1, 1, 1, 0);
        tbl[6].stim.da = 32'hABCD;
        // exp_stall, exp_valid, exp_rw, exp_rd, exp_da for the 1-bubble instance
        {tbl[0].exp_stall, tbl[0].exp_valid, tbl[0].exp_rw, tbl[0].exp_rd, tbl[0].exp_da} = {3'b000, 4'd0, 32'h0};
        {tbl[1].exp_stall, tbl[1].exp_valid, tbl[1].exp_rw, tbl[1].exp_rd, tbl[1].exp_da} = {3'b000, 4'd0, 32'h0};
        {tbl[2].exp_stall, tbl[2].exp_valid, tbl[2].exp_rw, tbl[2].exp_rd, tbl[2].exp_da} = {3'b011, 4'd5, 32'h1234};
        {tbl[3].exp_stall, tbl[3].exp_valid, tbl[3].exp_rw, tbl[3].exp_rd, tbl[3].exp_da} = {3'b011, 4'd3, 32'h0};
        {tbl[4].exp_stall, tbl[4].exp_valid, tbl[4].exp_rw, tbl[4].exp_rd, tbl[4].exp_da} = {3'b100, 4'd0, 32'h0};
        {tbl[5].exp_stall, tbl[5].exp_valid, tbl[5].exp_rw, tbl[5].exp_rd, tbl[5].exp_da} = {3'b011, 4'd4, 32'h0};
        {tbl[6].exp_stall, tbl[6].exp_valid, tbl[6].exp_rw, tbl[6].exp_rd, tbl[6].exp_da} = {3'b000, 4'd9, 32'hABCD};

        cur = tbl[0].stim;
        @(posedge clock);
        #1;
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].stim);
            chk($sformatf("tbl%0d stall", i), s_stall[0], tbl[i].exp_stall);
            chk($sformatf("tbl%0d pc_write", i), s_pc[0], !tbl[i].exp_stall);
            chk($sformatf("tbl%0d valid", i), q[0].valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d regWrite", i), q[0].rw, tbl[i].exp_rw);
            chk($sformatf("tbl%0d rd", i), q[0].rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d dataA", i), q[0].da, tbl[i].exp_da);
        end

        // Three bubbles through registerB (ALUSrc = 0)
        cycle(mk(1, 1, 2, 7, 1, 1, 1, 0));
        dep = mk(1, 1, 7, 6, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(dep);
            chk($sformatf("rb_hazard%0d stall", i), s_stall[1], i < 3);
            chk($sformatf("rb_hazard%0d valid", i), q[1].valid, i == 3);
            chk($sformatf("rb_hazard%0d rw", i), q[1].rw, i == 3);
        end

        // registerB ignored when the immediate is selected
        cycle(mk(1, 1, 2, 7, 1, 1, 1, 0));
        cycle(mk(1, 1, 7, 6, 1, 0, 1, 0));
        chk("imm_no_hazard stall", s_stall[1], 1'b0);
        chk("imm_no_hazard valid", q[1].valid, 1'b1);

        // Flush in the second stall cycle abandons the count
        cycle(mk(1, 1, 2, 7, 1, 1, 1, 0));
        dep = mk(1, 7, 0, 6, 1, 0, 1, 0);
        cycle(dep);
        chk("flush_pre stall", s_stall[1], 1'b1);
        dep.flush = 1'b1;
        cycle(dep);
        chk("flush stall", s_stall[1], 1'b0);
        chk("flush valid", q[1].valid, 1'b0);
        dep.flush = 1'b0;
        cycle(dep);
        chk("flush_post stall", s_stall[1], 1'b0);
        chk("flush_post rd", q[1].rd, 4'd6);

        // Downstream hold for four cycles
        cycle(mk(1, 1, 2, 8, 1, 0, 1, 0));
        dep = mk(1, 3, 4, 9, 1, 0, 1, 0);
        dep.ex_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(dep);
            chk($sformatf("hold%0d rd", i), q[1].rd, 4'd8);
            chk($sformatf("hold%0d valid", i), q[1].valid, 1'b1);
            chk($sformatf("hold%0d stall", i), s_stall[1], 1'b1);
            chk($sformatf("hold%0d pc_write", i), s_pc[1], 1'b0);
        end
        dep.ex_stall = 1'b0;
        cycle(dep);
        chk("hold_release stall", s_stall[1], 1'b0);
        chk("hold_release rd", q[1].rd, 4'd9);

        // Reset in the middle of a three-bubble stall
        cycle(mk(1, 1, 2, 7, 1, 1, 1, 0));
        dep = mk(1, 7, 0, 6, 1, 0, 1, 0);
        cycle(dep);
        dep.reset = 1'b0;
        cycle(dep);
        dep.reset = 1'b1;
        cycle(dep);
        chk("reset_mid stall", s_stall[1], 1'b0);
        chk("reset_mid valid", q[1].valid, 1'b1);
        chk("reset_mid rd", q[1].rd, 4'd6);

        for (int i = 0; i < 400; i++) cycle(rnd());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
